if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 208 ++++++++++++++++++++
 tb/tb_if_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Issues one word fetch at a time on a req/addr_ok/data_ok SRAM-style bus,
// buffers the returned instruction and hands it to decode with a
// valid/allowin handshake. A taken branch from decode redirects the fetch
// stream and kills any wrong-path instruction that is buffered or still in
// flight.
//
// Optional feature (compile-time macro FS_ADEF_CHECK_EN):
//   defined   : a fetch pc with pc[1:0] != 0 raises an address-error
//               exception. No SRAM request is made; {1, 32'h0, pc} is
//               presented to decode as a valid instruction.
//   undefined : bit 64 of fs_to_ds_bus is tied to 0 and the two low
//               address bits are forced to 0 on inst_sram_addr.
//
// Parameters
//   RESET_PC          first fetch address after reset
//
// Ports
//   clk               pipeline clock, rising edge
//   resetn            asynchronous active-low reset
//   ds_allowin        decode can accept an instruction this cycle
//   br_bus            {br_taken, br_target[31:0]} from decode
//   fs_to_ds_valid    fs_to_ds_bus carries a valid instruction
//   fs_to_ds_bus      {adef, inst[31:0], pc[31:0]}
//   inst_sram_req     fetch request
//   inst_sram_wr      always 0 (read only)
//   inst_sram_size    always 2'd2 (word)
//   inst_sram_addr    fetch address
//   inst_sram_addr_ok request accepted this cycle
//   inst_sram_data_ok read data returned this cycle
//   inst_sram_rdata   returned instruction word
// ----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam logic [31:0] PcStep = 32'd4;

  // StIssue    : request the word at r_pc (req=1 once out of reset)
  // StWaitData : request accepted, response outstanding
  // StHold     : instruction buffered in r_bus, waiting for decode
  typedef enum logic [1:0] {
    StIssue    = 2'd0,
    StWaitData = 2'd1,
    StHold     = 2'd2
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  // Response of the outstanding request belongs to a killed path.
  logic        r_cancel, w_cancel_nxt;
  // Redirect seen while a request waits for addr_ok; the address on the bus
  // must not change, so the target is parked here until acceptance.
  logic        r_redir_pend, w_redir_pend_nxt;
  logic [31:0] r_redir_pc, w_redir_pc_nxt;
  logic [64:0] r_bus, w_bus_nxt;
  // Keeps req low until the first clock edge after reset release.
  logic        r_started;

  logic        w_br_taken;
  logic [31:0] w_br_target;
  logic        w_redirect;
  logic        w_adef;
  logic        w_req;
  logic [31:0] w_fetch_addr;

  assign w_br_taken  = br_bus[32];
  assign w_br_target = br_bus[31:0];
  // A branch only redirects when decode actually consumes it this cycle.
  assign w_redirect  = w_br_taken & ds_allowin;

`ifdef FS_ADEF_CHECK_EN
  assign w_adef       = (r_pc[1:0] != 2'b00);
  assign w_fetch_addr = r_pc;
`else
  assign w_adef       = 1'b0;
  assign w_fetch_addr = {r_pc[31:2], 2'b00};
`endif

  assign w_req = r_started & (r_state == StIssue) & ~w_adef;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_cancel_nxt     = r_cancel;
    w_redir_pend_nxt = r_redir_pend;
    w_redir_pc_nxt   = r_redir_pc;
    w_bus_nxt        = r_bus;

    unique case (r_state)
      StIssue: begin
        if (w_req) begin
          if (inst_sram_addr_ok) begin
            w_state_nxt      = StWaitData;
            w_redir_pend_nxt = 1'b0;
            // Request went out for the old path: drop its response later and
            // move pc to the newest redirect target.
            if (w_redirect) begin
              w_cancel_nxt = 1'b1;
              w_pc_nxt     = w_br_target;
            end else if (r_redir_pend) begin
              w_cancel_nxt = 1'b1;
              w_pc_nxt     = r_redir_pc;
            end
          end else if (w_redirect) begin
            w_redir_pend_nxt = 1'b1;
            w_redir_pc_nxt   = w_br_target;
          end
        end else if (w_redirect) begin
          // No request on the bus, so pc can change immediately.
          w_pc_nxt = w_br_target;
        end else if (r_started && w_adef) begin
          w_state_nxt = StHold;
          w_bus_nxt   = {1'b1, 32'h0, r_pc};
        end
      end

      StWaitData: begin
        if (inst_sram_data_ok) begin
          if (r_cancel || w_redirect) begin
            w_state_nxt  = StIssue;
            w_cancel_nxt = 1'b0;
            if (w_redirect) begin
              w_pc_nxt = w_br_target;
            end
          end else begin
            w_state_nxt = StHold;
            w_bus_nxt   = {1'b0, inst_sram_rdata, r_pc};
          end
        end else if (w_redirect) begin
          w_cancel_nxt = 1'b1;
          w_pc_nxt     = w_br_target;
        end
      end

      StHold: begin
        if (w_redirect) begin
          // Buffered instruction is on the wrong path.
          w_state_nxt = StIssue;
          w_pc_nxt    = w_br_target;
        end else if (ds_allowin) begin
          w_state_nxt = StIssue;
          w_pc_nxt    = r_pc + PcStep;
        end
      end

      default: begin
        w_state_nxt = StIssue;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= StIssue;
      r_pc         <= RESET_PC;
      r_cancel     <= 1'b0;
      r_redir_pend <= 1'b0;
      r_redir_pc   <= 32'h0;
      r_bus        <= 65'h0;
      r_started    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_cancel     <= w_cancel_nxt;
      r_redir_pend <= w_redir_pend_nxt;
      r_redir_pc   <= w_redir_pc_nxt;
      r_bus        <= w_bus_nxt;
      r_started    <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Valid is gated in a redirect cycle so decode never consumes a wrong-path
  // instruction alongside its own branch.
  assign fs_to_ds_valid = (r_state == StHold) & ~w_redirect;
  assign fs_to_ds_bus   = r_bus;

  assign inst_sram_req  = w_req;
  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = 2'd2;
  assign inst_sram_addr = r_started ? w_fetch_addr : 32'h0;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1C000000;
  localparam int unsigned RandCycles = 4000;

  logic        clk;
  logic        resetn;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  if_stage #(
    .RESET_PC(RESET_PC)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .ds_allowin       (ds_allowin),
    .br_bus           (br_bus),
    .fs_to_ds_valid   (fs_to_ds_valid),
    .fs_to_ds_bus     (fs_to_ds_bus),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_wr     (inst_sram_wr),
    .inst_sram_size   (inst_sram_size),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Random-phase shared state
  logic        auto_en = 1'b0;
  logic [31:0] exp_q[$];   // next pc decode should receive
  logic [31:0] pend_q[$];  // accepted fetch addresses
  int          rdy_q[$];   // cycle at which each response returns
  int          pend_at_start = 0;
  int          cyc_n = 0;
  int          n_hs = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E3779B1) + 32'h01234567;
  endfunction

  task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Random stimulus + SRAM responder; pushes redirect expectations.
  // --------------------------------------------------------------------------
  initial begin
    logic [31:0] tgt;
    forever begin
      @(posedge clk);
      #1;
      if (!auto_en) begin
        pend_q.delete();
        rdy_q.delete();
        pend_at_start = 0;
      end else begin
        cyc_n++;
        pend_at_start     = pend_q.size();
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = $urandom;
        if (pend_q.size() > 0 && cyc_n >= rdy_q[0]) begin
          inst_sram_data_ok = 1'b1;
          inst_sram_rdata   = mem(pend_q[0]);
          void'(pend_q.pop_front());
          void'(rdy_q.pop_front());
        end else if (pend_q.size() == 0 && inst_sram_req && $urandom_range(0, 9) == 0) begin
          inst_sram_data_ok = 1'b1;  // stray response while issuing
        end
        inst_sram_addr_ok = 1'b0;
        if (inst_sram_req && $urandom_range(0, 2) != 0) begin
          inst_sram_addr_ok = 1'b1;
          pend_q.push_back(inst_sram_addr);
          rdy_q.push_back(cyc_n + int'($urandom_range(1, 3)));
        end
        ds_allowin = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 7) == 0) tgt = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFC
                                                                         : 32'hFFFFFFF8;
          else tgt = {16'h1C00, 14'($urandom), 2'b00};
          br_bus = {1'b1, tgt};
          if (ds_allowin) begin
            exp_q.delete();
            exp_q.push_back(tgt);
          end
        end else begin
          br_bus = {1'b0, 32'($urandom)};
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: compares delivered instructions and bus protocol rules.
  // --------------------------------------------------------------------------
  initial begin
    logic        prev_ok, p_req, p_aok, p_valid, p_allow, redir_now;
    logic [31:0] p_addr, e;
    logic [64:0] p_bus;
    prev_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (!auto_en) begin
        prev_ok = 1'b0;
      end else begin
        redir_now = br_bus[32] & ds_allowin;
        if (pend_at_start != 0) chk("one_outstanding", 65'(inst_sram_req), 65'd0);
        if (redir_now) chk("redirect_gates_valid", 65'(fs_to_ds_valid), 65'd0);
        if (prev_ok && p_req && !p_aok) begin
          chk("req_held", 65'(inst_sram_req), 65'd1);
          chk("addr_held", 65'(inst_sram_addr), 65'(p_addr));
        end
        if (prev_ok && p_valid && !p_allow && !redir_now) begin
          chk("valid_held", 65'(fs_to_ds_valid), 65'd1);
          chk("bus_held", fs_to_ds_bus, p_bus);
        end
        if (fs_to_ds_valid && ds_allowin) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL deliver_unexpected got=%h exp=none", fs_to_ds_bus);
          end else begin
            e = exp_q.pop_front();
            chk("deliver", fs_to_ds_bus, {1'b0, mem(e), e});
            exp_q.push_back(e + 32'd4);
            n_hs++;
          end
        end
        p_req   = inst_sram_req;
        p_aok   = inst_sram_addr_ok;
        p_addr  = inst_sram_addr;
        p_valid = fs_to_ds_valid;
        p_allow = ds_allowin;
        p_bus   = fs_to_ds_bus;
        prev_ok = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed scenarios, then the random phase.
  // --------------------------------------------------------------------------
  initial begin
    resetn = 1'b0;
    ds_allowin = 1'b0;
    br_bus = '0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata = '0;
    repeat (2) samp();
    chk("rst_valid", 65'(fs_to_ds_valid), 65'd0);
    chk("rst_bus", fs_to_ds_bus, 65'd0);
    chk("rst_req", 65'(inst_sram_req), 65'd0);
    chk("rst_addr", 65'(inst_sram_addr), 65'd0);
    tick(); resetn = 1'b1;
    samp(); chk("req_before_first_edge", 65'(inst_sram_req), 65'd0);

    // First fetch: addr_ok same cycle, data_ok two cycles later.
    tick(); inst_sram_addr_ok = 1'b1;
    samp(); chk("first_req", 65'(inst_sram_req), 65'd1);
    chk("first_addr", 65'(inst_sram_addr), 65'(RESET_PC));
    tick(); inst_sram_addr_ok = 1'b0;
    samp(); chk("wait_req_low", 65'(inst_sram_req), 65'd0);
    tick(); inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h02800421;
    samp(); chk("valid_not_early", 65'(fs_to_ds_valid), 65'd0);
    tick(); inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'hA5A5A5A5;
    // Decode stalls for five cycles.
    for (int i = 0; i < 5; i++) begin
      if (i != 0) tick();
      samp();
      chk("hold_valid", 65'(fs_to_ds_valid), 65'd1);
      chk("hold_bus", fs_to_ds_bus, {1'b0, 32'h02800421, RESET_PC});
      chk("hold_req_low", 65'(inst_sram_req), 65'd0);
    end
    tick(); ds_allowin = 1'b1;
    samp(); chk("consume_valid", 65'(fs_to_ds_valid), 65'd1);
    tick(); ds_allowin = 1'b0; inst_sram_addr_ok = 1'b1;
    samp(); chk("seq_addr", 65'(inst_sram_addr), 65'h1C000004);
    chk("valid_dropped", 65'(fs_to_ds_valid), 65'd0);

    // Redirect while waiting for data: response is dropped.
    tick(); inst_sram_addr_ok = 1'b0; br_bus = {1'b1, 32'h1C000100}; ds_allowin = 1'b1;
    samp(); chk("wd_redir_valid", 65'(fs_to_ds_valid), 65'd0);
    tick(); br_bus = '0; ds_allowin = 1'b0; inst_sram_data_ok = 1'b1;
    inst_sram_rdata = 32'hDEADBEEF;
    samp(); chk("wd_drop_valid", 65'(fs_to_ds_valid), 65'd0);
    // Redirect with a pending request whose addr_ok comes 3 cycles late.
    tick(); inst_sram_data_ok = 1'b0; br_bus = {1'b1, 32'h1C000200}; ds_allowin = 1'b1;
    samp(); chk("wd_valid_after_drop", 65'(fs_to_ds_valid), 65'd0);
    chk("wd_target_addr", 65'(inst_sram_addr), 65'h1C000100);
    chk("wd_target_req", 65'(inst_sram_req), 65'd1);
    for (int i = 0; i < 2; i++) begin
      tick(); br_bus = '0; ds_allowin = 1'b0;
      samp(); chk("pend_req_held", 65'(inst_sram_req), 65'd1);
      chk("pend_addr_held", 65'(inst_sram_addr), 65'h1C000100);
    end
    tick(); inst_sram_addr_ok = 1'b1;
    samp(); chk("pend_addr_at_ok", 65'(inst_sram_addr), 65'h1C000100);
    tick(); inst_sram_addr_ok = 1'b0;
    samp(); chk("pend_wait_req", 65'(inst_sram_req), 65'd0);
    tick(); inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h11111111;
    tick(); inst_sram_data_ok = 1'b0; inst_sram_addr_ok = 1'b1;
    samp(); chk("pend_drop_valid", 65'(fs_to_ds_valid), 65'd0);
    chk("pend_target_addr", 65'(inst_sram_addr), 65'h1C000200);
    tick(); inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h22222222;
    // Redirect from HOLD to the top word of the address space.
    tick(); inst_sram_data_ok = 1'b0; br_bus = {1'b1, 32'hFFFFFFFC}; ds_allowin = 1'b1;
    samp(); chk("hold_redir_gated", 65'(fs_to_ds_valid), 65'd0);
    tick(); br_bus = '0; ds_allowin = 1'b0; inst_sram_addr_ok = 1'b1;
    samp(); chk("top_addr", 65'(inst_sram_addr), 65'hFFFFFFFC);
    tick(); inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h33333333;
    tick(); inst_sram_data_ok = 1'b0; ds_allowin = 1'b1;
    samp(); chk("top_bus", fs_to_ds_bus, {1'b0, 32'h33333333, 32'hFFFFFFFC});
    tick(); ds_allowin = 1'b0; inst_sram_addr_ok = 1'b1;
    samp(); chk("wrap_addr", 65'(inst_sram_addr), 65'h0);
    chk("wrap_req", 65'(inst_sram_req), 65'd1);
    // Redirect coinciding with data_ok.
    tick(); inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h44444444;
    br_bus = {1'b1, 32'h1C000300}; ds_allowin = 1'b1;
    tick(); inst_sram_data_ok = 1'b1; br_bus = '0; ds_allowin = 1'b0;  // stray data_ok
    samp(); chk("coinc_valid", 65'(fs_to_ds_valid), 65'd0);
    chk("coinc_addr", 65'(inst_sram_addr), 65'h1C000300);
    tick(); inst_sram_data_ok = 1'b0; inst_sram_addr_ok = 1'b1;
    samp(); chk("stray_ignored_valid", 65'(fs_to_ds_valid), 65'd0);
    chk("stray_ignored_req", 65'(inst_sram_req), 65'd1);
    // Reset in the middle of a transaction.
    tick(); inst_sram_addr_ok = 1'b0; resetn = 1'b0;
    samp(); chk("midrst_req", 65'(inst_sram_req), 65'd0);
    chk("midrst_addr", 65'(inst_sram_addr), 65'd0);
    chk("midrst_bus", fs_to_ds_bus, 65'd0);
    tick(); resetn = 1'b1;
    tick(); inst_sram_data_ok = 1'b1;  // stale response after reset
    samp(); chk("midrst_refetch", 65'(inst_sram_addr), 65'(RESET_PC));
    chk("midrst_refetch_req", 65'(inst_sram_req), 65'd1);
    // Misaligned branch target.
    tick(); inst_sram_data_ok = 1'b0; br_bus = {1'b1, 32'h1C000102}; ds_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1;
    tick(); br_bus = '0; ds_allowin = 1'b0; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1;
    tick(); inst_sram_data_ok = 1'b0;
`ifdef FS_ADEF_CHECK_EN
    samp(); chk("adef_no_req", 65'(inst_sram_req), 65'd0);
    tick();
    samp(); chk("adef_valid", 65'(fs_to_ds_valid), 65'd1);
    chk("adef_bus", fs_to_ds_bus, {1'b1, 32'h0, 32'h1C000102});
    chk("adef_no_req_hold", 65'(inst_sram_req), 65'd0);
`else
    samp(); chk("misalign_req", 65'(inst_sram_req), 65'd1);
    chk("misalign_addr", 65'(inst_sram_addr), 65'h1C000100);
`endif

    // Random phase from a fresh reset.
    tick(); resetn = 1'b0; ds_allowin = 1'b0; br_bus = '0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
    tick(); resetn = 1'b1;
    @(posedge clk); #3;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    auto_en = 1'b1;
    repeat (RandCycles) @(posedge clk);
    #3 auto_en = 1'b0;
    samp();
    total++;
    if (n_hs < 100) begin
      bad++;
      $display("FAIL liveness got=%0d handshakes exp>=100", n_hs);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
